// File: rtl/pwm_deadtime_gen.sv
// Complementary gate generator for one inverter leg: valley-reloaded duty compare,
// programmable dead time, enable gating and a latched fault shutdown.
module pwm_deadtime_gen #(
  parameter int DT_W     = 10,
  parameter int FLT_SYNC = 2
) (
  input  logic            clk_20M,
  input  logic            reset_n,
  input  logic [15:0]     carrier,
  input  logic            carrier_dir,
  input  logic [15:0]     carrier_period,
  input  logic [15:0]     duty_cmd,
  input  logic            duty_wr,
  input  logic [DT_W-1:0] deadtime,
  input  logic            pwm_en,
  input  logic            fault_n,
  input  logic            fault_clr,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic [15:0]     duty_active,
  output logic            fault_latched,
  output logic            valley
);

  // state | meaning
  // IDLE  | both gates low, waiting for enable
  // L_ON  | low-side gate on
  // H_ON  | high-side gate on
  // DT_H  | both low, dead time before high side
  // DT_L  | both low, dead time before low side
  // FAULT | both low until the fault latch is cleared
  typedef enum logic [2:0] {IDLE, L_ON, H_ON, DT_H, DT_L, FAULT} state_t;

  state_t              state, state_nxt;
  logic [DT_W-1:0]     cnt, cnt_nxt;
  logic [15:0]         shadow;
  logic                raw_q;
  logic [FLT_SYNC-1:0] flt_sync;
  logic                flt;
  logic                dt_done;

  // Reload keys on the valley value alone, so direction is not needed here.
  logic unused_dir;
  assign unused_dir = carrier_dir;

  assign flt     = flt_sync[FLT_SYNC-1];
  assign dt_done = (cnt == '0) || (cnt == DT_W'(1));

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      flt_sync      <= '1;
      fault_latched <= 1'b0;
      shadow        <= '0;
      duty_active   <= '0;
      valley        <= 1'b0;
      raw_q         <= 1'b0;
    end else begin
      flt_sync <= {flt_sync[FLT_SYNC-2:0], fault_n};
      if (!flt)
        fault_latched <= 1'b1;
      else if (fault_clr && !pwm_en)
        fault_latched <= 1'b0;
      if (duty_wr)
        shadow <= (duty_cmd > carrier_period) ? carrier_period : duty_cmd;
      valley <= (carrier == '0);
      if (carrier == '0)
        duty_active <= shadow;
      raw_q <= (carrier < duty_active);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (pwm_en && !fault_latched) begin
        state_nxt = raw_q ? DT_H : DT_L;
        cnt_nxt   = deadtime;
      end
      L_ON: if (raw_q) begin
        state_nxt = (deadtime == '0) ? H_ON : DT_H;
        cnt_nxt   = deadtime;
      end
      H_ON: if (!raw_q) begin
        state_nxt = (deadtime == '0) ? L_ON : DT_L;
        cnt_nxt   = deadtime;
      end
      DT_H: begin
        if (!raw_q)       state_nxt = L_ON;
        else if (dt_done) state_nxt = H_ON;
        else              cnt_nxt   = cnt - DT_W'(1);
      end
      DT_L: begin
        if (raw_q)        state_nxt = H_ON;
        else if (dt_done) state_nxt = L_ON;
        else              cnt_nxt   = cnt - DT_W'(1);
      end
      FAULT: if (!fault_latched) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != FAULT && !pwm_en) state_nxt = IDLE;
    if (!flt)                      state_nxt = FAULT;
  end

  // Gates are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pwm_h <= (state_nxt == H_ON);
      pwm_l <= (state_nxt == L_ON);
    end
  end

endmodule
